// File: rtl/genius_pkg.sv
// ============================================================================
// Module  : genius_pkg
// Purpose : Shared colour codes, player state encoding and LFSR taps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package genius_pkg;

   localparam logic [1:0] COLOR_GREEN  = 2'b00;
   localparam logic [1:0] COLOR_RED    = 2'b01;
   localparam logic [1:0] COLOR_YELLOW = 2'b10;
   localparam logic [1:0] COLOR_BLUE   = 2'b11;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPEND = 3'd1,
      ST_ON     = 3'd2,
      ST_OFF    = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/genius_lfsr.sv
// ============================================================================
// Module  : genius_lfsr
// Purpose : Free-running 16-bit Galois LFSR; exposes the two low bits as a colour.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module genius_lfsr
   import genius_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] color_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign color_o = lfsr_q[1:0];

endmodule

`default_nettype wire

// File: rtl/genius_seq_player.sv
// ============================================================================
// Module  : genius_seq_player
// Purpose : Grows the Genius colour sequence and plays it back as timed steps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module genius_seq_player
   import genius_pkg::*;
#(
   parameter int          MAX_LEN    = 32,
   parameter int          ON_CYCLES  = 4,
   parameter int          OFF_CYCLES = 2,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           start,
   input  logic                           replay,
   input  logic [$clog2(MAX_LEN)-1:0]     rd_idx,
   output logic [1:0]                     rd_color,
   output logic [1:0]                     sel_out,
   output logic                           show,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(MAX_LEN+1)-1:0]   len,
   output logic                           full
);

   localparam int IW   = $clog2(MAX_LEN);
   localparam int LW   = $clog2(MAX_LEN + 1);
   localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

   state_e         state_q, state_d;
   logic [LW-1:0]  len_q, len_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           wr_en;
   logic           full_w;
   logic           last_w;
   logic [1:0]     rnd_color;
   logic [1:0]     mem_q [MAX_LEN];

   genius_lfsr #(
      .SEED    (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .color_o (rnd_color)
   );

   assign full_w = (len_q == LW'(MAX_LEN));
   assign last_w = ((LW'(idx_q) + LW'(1)) == len_q);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      wr_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_APPEND;
            end else if (replay) begin
               if (len_q != '0) begin
                  state_d = ST_ON;
                  idx_d   = '0;
                  timer_d = ON_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_APPEND: begin
            // A full sequence is still played back, just not extended
            if (!full_w) begin
               wr_en = 1'b1;
               len_d = len_q + LW'(1);
            end
            idx_d   = '0;
            timer_d = ON_LOAD;
            state_d = ST_ON;
         end
         ST_ON: begin
            if (timer_q == '0) begin
               state_d = ST_OFF;
               timer_d = OFF_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ST_OFF: begin
            if (timer_q == '0) begin
               if (last_w) begin
                  state_d = ST_DONE;
                  timer_d = '0;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ST_ON;
                  timer_d = ON_LOAD;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear) begin
         state_d = ST_IDLE;
         len_d   = '0;
         idx_d   = '0;
         timer_d = '0;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[IW'(len_q)] <= rnd_color;
      end
   end

   // idx only advances on OFF->ON, so OFF keeps showing the last colour
   assign sel_out  = ((state_q == ST_ON) || (state_q == ST_OFF)) ? mem_q[idx_q] : 2'b00;
   assign show     = (state_q == ST_ON);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign rd_color = mem_q[rd_idx];
   assign len      = len_q;
   assign full     = full_w;

endmodule

`default_nettype wire
